// File: rtl/atta_trace_uart.sv
// atta_trace_uart: captures 36-bit trace words into a small FIFO and streams
// each entry out as a 5-byte 8N1 UART frame. A trap freezes further capture.
module atta_trace_uart #(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_AW     = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               trace_valid_i,
  input  logic [35:0]        trace_data_i,
  input  logic               trap_i,
  output logic               uart_tx_o,
  output logic               overflow_o,
  output logic               frozen_o,
  output logic [FIFO_AW:0]   level_o
);

  localparam int unsigned DIV   = CLK_FREQ_HZ / BAUD;
  localparam int unsigned CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned LW    = FIFO_AW + 1;
  localparam int unsigned EW    = 37;

  // Bit period must span at least two clocks.
  if (DIV < 2) begin : g_div_check
    $error("atta_trace_uart: CLK_FREQ_HZ/BAUD must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        div_cnt_q;
  logic [2:0]           bit_idx_q;
  logic [2:0]           byte_idx_q;
  logic [EW-1:0]        frame_q;
  logic                 tx_q, tx_d;
  logic [7:0]           cur_byte_c;

  logic [EW-1:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        level_q;
  logic                 overflow_q, frozen_q, drop_pending_q;

  logic capture_c, full_c, push_c, drop_c, pop_c, bit_end_c;

  // Fullness is judged on the pre-pop level so a full FIFO drops even on a pop cycle.
  assign capture_c = trace_valid_i && !frozen_q;
  assign full_c    = (level_q == LW'(DEPTH));
  assign push_c    = capture_c && !full_c;
  assign drop_c    = capture_c && full_c;
  assign pop_c     = (state_q == S_IDLE) && (level_q != '0);
  assign bit_end_c = (div_cnt_q == CW'(DIV - 1));

  // FIFO pointers, occupancy and sticky status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      overflow_q     <= 1'b0;
      frozen_q       <= 1'b0;
      drop_pending_q <= 1'b0;
    end else begin
      if (trap_i) frozen_q <= 1'b1;
      if (push_c) begin
        wr_ptr_q       <= wr_ptr_q + FIFO_AW'(1);
        drop_pending_q <= 1'b0;
      end
      if (drop_c) begin
        overflow_q     <= 1'b1;
        drop_pending_q <= 1'b1;
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      if (push_c && !pop_c) begin
        level_q <= level_q + LW'(1);
      end else if (!push_c && pop_c) begin
        level_q <= level_q - LW'(1);
      end
    end
  end

  // FIFO storage; each entry carries the drop flag above the trace word.
  always_ff @(posedge clk_i) begin
    if (push_c) mem_q[wr_ptr_q] <= {drop_pending_q, trace_data_i};
  end

  // Serializer state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Serializer next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (pop_c) state_d = S_START;
      S_START: if (bit_end_c) state_d = S_DATA;
      S_DATA:  if (bit_end_c && (bit_idx_q == 3'd7)) state_d = S_STOP;
      S_STOP:  if (bit_end_c) state_d = (byte_idx_q == 3'd4) ? S_IDLE : S_START;
      default: state_d = S_IDLE;
    endcase
  end

  // Serializer output: select the current byte and the line level for this state.
  always_comb begin
    cur_byte_c = frame_q[7:0];
    tx_d       = 1'b1;
    unique case (byte_idx_q)
      3'd0:    cur_byte_c = {1'b1, frame_q[36], 2'b00, frame_q[35:32]};
      3'd1:    cur_byte_c = frame_q[31:24];
      3'd2:    cur_byte_c = frame_q[23:16];
      3'd3:    cur_byte_c = frame_q[15:8];
      default: cur_byte_c = frame_q[7:0];
    endcase
    unique case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte_c[bit_idx_q];
      default: tx_d = 1'b1;
    endcase
  end

  // Serializer datapath: bit timer, bit/byte indices, frame holding register, line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_q       <= 1'b1;
      div_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      frame_q    <= '0;
    end else begin
      tx_q <= tx_d;
      if ((state_q == S_IDLE) || bit_end_c) div_cnt_q <= '0;
      else                                  div_cnt_q <= div_cnt_q + CW'(1);
      if (pop_c) begin
        frame_q    <= mem_q[rd_ptr_q];
        byte_idx_q <= '0;
      end
      if ((state_q == S_START) && bit_end_c) bit_idx_q <= '0;
      if ((state_q == S_DATA) && bit_end_c)  bit_idx_q <= bit_idx_q + 3'd1;
      if ((state_q == S_STOP) && bit_end_c && (byte_idx_q != 3'd4))
        byte_idx_q <= byte_idx_q + 3'd1;
    end
  end

  assign uart_tx_o  = tx_q;
  assign overflow_o = overflow_q;
  assign frozen_o   = frozen_q;
  assign level_o    = level_q;

endmodule

// File: tb/tb_atta_trace_uart.sv
// Scoreboard bench for atta_trace_uart: expected bytes are queued with each
// push; a UART decoder pops and compares every received byte.
module tb_atta_trace_uart;

  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        trace_valid_i;
  logic [35:0] trace_data_i;
  logic        trap_i;
  logic        uart_tx_o;
  logic        overflow_o;
  logic        frozen_o;
  logic [2:0]  level_o;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  bit   mon_ignore = 1'b0;
  logic [7:0] exp_q[$];

  atta_trace_uart #(
    .CLK_FREQ_HZ(1000),
    .BAUD       (100),
    .FIFO_AW    (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .trace_valid_i(trace_valid_i),
    .trace_data_i (trace_data_i),
    .trap_i       (trap_i),
    .uart_tx_o    (uart_tx_o),
    .overflow_o   (overflow_o),
    .frozen_o     (frozen_o),
    .level_o      (level_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_edge(input int t);
    while (cyc < t) tick();
  endtask

  // Drive one valid word so that it is sampled at the next rising edge; e = that edge.
  task automatic push(input logic [35:0] d, output int e);
    @(negedge clk);
    trace_valid_i = 1'b1;
    trace_data_i  = d;
    @(posedge clk);
    #1;
    trace_valid_i = 1'b0;
    e = cyc;
  endtask

  task automatic exp_word(input logic [35:0] d, input logic drop);
    exp_q.push_back({1'b1, drop, 2'b00, d[35:32]});
    exp_q.push_back(d[31:24]);
    exp_q.push_back(d[23:16]);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  // Wait for all expected bytes to be received, then let the line settle.
  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 4000) begin
      tick();
      k++;
    end
    chk(name, exp_q.size(), 0);
    repeat (150) tick();
    chk({name, "_level"}, level_o, 0);
  endtask

  // UART decoder: samples mid-bit on falling clock edges and scores each byte.
  initial begin : monitor
    logic       prev;
    logic [7:0] b;
    logic [7:0] e;
    logic       start_b, stop_b;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && uart_tx_o === 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        start_b = uart_tx_o;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = uart_tx_o;
        end
        repeat (DIV) @(negedge clk);
        stop_b = uart_tx_o;
        if (!mon_ignore) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL uart_byte: got %02h expected none (cycle %0d)", b, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("uart_byte", {stop_b, b, start_b}, {1'b1, e, 1'b0});
          end
        end
      end
      prev = uart_tx_o;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    int e, e1, a, x;
    int low_seen;
    rst_i = 1'b1;
    trace_valid_i = 1'b0;
    trace_data_i = '0;
    trap_i = 1'b0;
    tick();
    tick();
    chk("rst_tx", uart_tx_o, 1);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_frozen", frozen_o, 0);
    chk("rst_level", level_o, 0);
    rst_i = 1'b0;
    tick();

    // Single word: latency and frame length.
    exp_word(36'h9_A5C3_0F12, 1'b0);
    push(36'h9_A5C3_0F12, e);
    at_edge(e + 1);
    chk("t1_tx_n1", uart_tx_o, 1);
    at_edge(e + 2);
    chk("t1_tx_n2", uart_tx_o, 0);
    chk("t1_level", level_o, 0);
    at_edge(e + 2 + 489);
    chk("t1_b4_bit7", uart_tx_o, 0);
    at_edge(e + 2 + 490);
    chk("t1_stop", uart_tx_o, 1);
    drain("t1_drain");

    // Burst overflow: 6 back-to-back pushes, the 6th is dropped.
    e1 = 0;
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) exp_word(36'(i), 1'b0);
      push(36'(i), e);
      if (i == 1) e1 = e;
    end
    chk("t2_level_full", level_o, 4);
    chk("t2_overflow", overflow_o, 1);
    at_edge(e1 + 510);
    chk("t2_level_after_pop", level_o, 3);
    exp_word(36'h0_0000_0007, 1'b1);
    push(36'h0_0000_0007, e);
    chk("t2_level_refill", level_o, 4);
    drain("t2_drain");

    // Full FIFO with a push on the exact cycle of a pop.
    do_reset();
    chk("t3_overflow_rst", overflow_o, 0);
    a = 0;
    for (int i = 1; i <= 5; i++) begin
      exp_word(36'hA_0000_00A0 + 36'(i), 1'b0);
      push(36'hA_0000_00A0 + 36'(i), e);
      if (i == 1) a = e;
    end
    at_edge(a + 501);
    chk("t3_level_pre", level_o, 4);
    chk("t3_overflow_pre", overflow_o, 0);
    push(36'hB_BBBB_BBBB, x);
    chk("t3_level_post", level_o, 3);
    chk("t3_overflow_post", overflow_o, 1);
    exp_word(36'h3_0000_00FF, 1'b1);
    push(36'h3_0000_00FF, e);
    drain("t3_drain");

    // Back-to-back frames: one idle-high cycle between frames.
    do_reset();
    exp_word(36'h5_1234_5678, 1'b0);
    exp_word(36'h6_8765_4321, 1'b0);
    push(36'h5_1234_5678, e);
    push(36'h6_8765_4321, x);
    at_edge(e + 2 + 489);
    chk("t4_b4_bit7", uart_tx_o, 0);
    at_edge(e + 501);
    chk("t4_stop_end", uart_tx_o, 1);
    at_edge(e + 502);
    chk("t4_idle", uart_tx_o, 1);
    at_edge(e + 503);
    chk("t4_start2", uart_tx_o, 0);
    drain("t4_drain");

    // Trap freeze: the word alongside the trap is kept, later ones ignored.
    chk("t5_frozen_pre", frozen_o, 0);
    exp_word(36'h7_0000_0011, 1'b0);
    exp_word(36'h7_0000_0022, 1'b0);
    exp_word(36'h7_0000_0033, 1'b0);
    push(36'h7_0000_0011, e);
    push(36'h7_0000_0022, e);
    trap_i = 1'b1;
    push(36'h7_0000_0033, e);
    chk("t5_frozen", frozen_o, 1);
    push(36'h7_0000_0044, e);
    push(36'h7_0000_0055, e);
    push(36'h7_0000_0066, e);
    trap_i = 1'b0;
    drain("t5_drain");
    chk("t5_frozen_sticky", frozen_o, 1);
    chk("t5_overflow", overflow_o, 0);

    // Reset in the middle of B2 data bits.
    do_reset();
    chk("t6_frozen_rst", frozen_o, 0);
    mon_ignore = 1'b1;
    push(36'h0_FF00_FF00, e);
    push(36'h0_1111_1111, x);
    at_edge(e + 2 + 229);
    chk("t6_tx_pre", uart_tx_o, 0);
    chk("t6_level_pre", level_o, 1);
    rst_i = 1'b1;
    tick();
    chk("t6_tx_post", uart_tx_o, 1);
    chk("t6_level_post", level_o, 0);
    rst_i = 1'b0;
    low_seen = 0;
    repeat (700) begin
      tick();
      if (uart_tx_o !== 1'b1) low_seen++;
    end
    chk("t6_line_quiet", low_seen, 0);
    mon_ignore = 1'b0;
    chk("t6_exp_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/atta_trace_uart.md
Name: atta_trace_uart

Overview:
- Downstream consumer of the atta_system trace port.
- Captures 36-bit trace words into a small synchronous FIFO and streams each entry out over an 8N1 UART TX line, so instruction traces from the soft core are observable on a bench host without a logic analyser.
- Sits in the top level beside the LED/GPIO mapping, clocked from the 100 MHz system clock. It also takes the core trap flag to freeze capture after a trap.

Parameters:
- CLK_FREQ_HZ, 100000000: system clock frequency in Hz.
- BAUD, 115200: UART bit rate. DIV = CLK_FREQ_HZ/BAUD, rounded down. DIV must be at least 2; elaboration fails otherwise.
- FIFO_AW, 4: FIFO address width. Depth = 2**FIFO_AW entries of 36 bits.

Ports:
- clk_i  input  1  system clock; all logic on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- trace_valid_i  input  1  trace word strobe from the core; one entry per high cycle.
- trace_data_i  input  36  trace word, sampled when trace_valid_i=1.
- trap_i  input  1  core trap flag (level).
- uart_tx_o  output  1  serial output, idle high.
- overflow_o  output  1  sticky: at least one trace word has been dropped since reset.
- frozen_o  output  1  sticky: capture halted because trap_i was seen high.
- level_o  output  FIFO_AW+1  current FIFO occupancy, 0..2**FIFO_AW.

Behaviour:
- Reset values (rst_i high at a clock edge):
  - uart_tx_o=1, overflow_o=0, frozen_o=0, level_o=0.
  - FIFO empty, serializer in IDLE, drop_pending=0.
  - Reset mid-frame aborts the frame immediately; the line returns high on the next cycle.
- Capture:
  - frozen_o sets on the first cycle trap_i=1 (registered, visible the next cycle).
  - In the same cycle trap_i rises, a valid word is still captured; from the next cycle all trace_valid_i are ignored and are not counted as drops.
  - Push condition: trace_valid_i=1 and frozen_o=0.
  - Fullness is evaluated before any same-cycle pop. If level_o equals depth, the word is dropped even if a pop occurs that cycle.
  - On a drop: overflow_o is set (sticky) and drop_pending is set.
  - The next accepted word is stored with its drop flag=1, and drop_pending clears in that cycle.
  - level_o updates the cycle after a push/pop. Simultaneous accepted push and pop leave it unchanged.
- Frame format (5 bytes per entry, bytes sent in order):
  - B0 = {1'b1, drop_flag, 2'b00, data[35:32]}
  - B1 = data[31:24], B2 = data[23:16], B3 = data[15:8], B4 = data[7:0]
- Byte serialisation: start bit 0, 8 data bits LSB first, stop bit 1. Each bit is held exactly DIV cycles.
- Serializer FSM:
  - IDLE: uart_tx_o=1. If FIFO non-empty, pop the head into a 37-bit shift register, byte_idx=0, go to START.
  - START: drive 0 for DIV cycles, then go to DATA with bit_idx=0.
  - DATA: drive the current bit for DIV cycles. After bit 7, go to STOP.
  - STOP: drive 1 for DIV cycles. If byte_idx<4, increment byte_idx and go to START. Otherwise go to IDLE.
- Latency and spacing:
  - A word accepted at edge N into an empty FIFO with the serializer IDLE is popped at edge N+1. uart_tx_o falls at edge N+2.
  - Bytes within a frame are back-to-back, with no idle cycles.
  - Consecutive frames are separated by exactly one IDLE cycle (uart_tx_o=1).
  - One frame lasts 50*DIV cycles.
- FIFO pointers wrap modulo depth. The level counter never exceeds depth and never goes below 0.
- Once frozen, the FIFO continues to drain normally. frozen_o and overflow_o clear only on reset.

Test Plan (bench uses CLK_FREQ_HZ=1000, BAUD=100, so DIV=10; FIFO_AW=2, so depth 4):
- Single word: reset, then one push of 36'h9_A5C3_0F12 → uart_tx_o falls 2 cycles after the push edge. Decoded bytes are 0x89, 0xA5, 0xC3, 0x0F, 0x12. The frame lasts 500 cycles, and level_o returns to 0.
- Burst overflow: 6 back-to-back pushes 36'h0_0000_0001..6 with the serializer idle → entry 1 pops immediately, entries 2..5 fill the FIFO and entry 6 is dropped, so overflow_o=1. The next push, 36'h0_0000_0007, is sent with B0=0xC0. Earlier frames have B0=0x80.
- Full plus pop same cycle: with level_o=4, push on the exact cycle the serializer pops → the word is dropped, level_o=3, overflow_o=1.
- Trap freeze: push 2 words, assert trap_i with a third valid in the same cycle, then 3 more valids → exactly 3 frames transmitted, frozen_o=1, overflow_o=0.
- Reset mid-frame: assert rst_i during DATA of B2 → uart_tx_o=1 from the next cycle, level_o=0, and no further transitions occur with no pushes.
- Back-to-back frames: 2 words queued → exactly one cycle of idle-high between the B4 stop bit of frame 1 and the start bit of frame 2.
